// File: rtl/food_spawner_if.sv
// Handshake bundle between the food spawner and its surroundings:
// seeding, spawn request, body-storage query/answer and the food result.
// The master modport is the game side, the slave modport is the spawner.
interface food_spawner_if;
  logic [11:0] randomseed;
  logic        seed_load;
  logic        spawn_req;
  logic        occupied;
  logic        query_valid;
  logic [4:0]  query_x;
  logic [4:0]  query_y;
  logic        food_valid;
  logic [4:0]  food_x;
  logic [4:0]  food_y;
  logic        busy;
  logic        spawn_fail;

  modport master (
    output randomseed, seed_load, spawn_req, occupied,
    input  query_valid, query_x, query_y, food_valid, food_x, food_y, busy, spawn_fail
  );

  modport slave (
    input  randomseed, seed_load, spawn_req, occupied,
    output query_valid, query_x, query_y, food_valid, food_x, food_y, busy, spawn_fail
  );
endinterface

// File: rtl/food_spawner.sv
// Food spawner for the snake game.
// A 12-bit LFSR draws candidate cells; in-range candidates are checked
// against the snake body through a query/occupied handshake and the first
// free cell becomes the new food position.
// Optional feature macro: FOOD_LINEAR_PROBE_EN -- when random draws run out,
// fall back to a raster scan of the grid instead of reporting failure.
module food_spawner #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_TRIES = 16
) (
  input logic           OSC,
  input logic           rst,
  food_spawner_if.slave bus
);

  localparam logic [11:0] LFSR_INIT   = 12'hDCF;
  localparam logic [5:0]  GRID_W_L    = 6'(GRID_W);
  localparam logic [5:0]  GRID_H_L    = 6'(GRID_H);
  localparam logic [7:0]  MAX_TRIES_L = 8'(MAX_TRIES);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_STEP    = 4'd1,
    ST_CHECK   = 4'd2,
    ST_QUERY   = 4'd3,
    ST_WAIT    = 4'd4,
    ST_DONE    = 4'd5,
`ifdef FOOD_LINEAR_PROBE_EN
    ST_FAIL    = 4'd6,
    ST_PROBE_Q = 4'd7,
    ST_PROBE_W = 4'd8
`else
    ST_FAIL    = 4'd6
`endif
  } state_t;

  // Where the FSM goes once the random-draw budget is used up.
`ifdef FOOD_LINEAR_PROBE_EN
  localparam state_t ST_EXHAUST = ST_PROBE_Q;
`else
  localparam state_t ST_EXHAUST = ST_FAIL;
`endif

  // Feedback taps 11,10,9,3 folded into one parity bit.
  function automatic logic lfsr_fb(input logic [11:0] v);
    return v[11] ^ v[10] ^ v[9] ^ v[3];
  endfunction

  function automatic logic [11:0] lfsr_step(input logic [11:0] v);
    return {v[10:0], lfsr_fb(v)};
  endfunction

  state_t      state_r, state_nxt_s;
  logic [11:0] lfsr_r;
  logic [7:0]  tries_r;
  logic [4:0]  cand_x_s, cand_y_s;
  logic        in_range_s, exhausted_s;
  logic        query_valid_r, food_valid_r, busy_r, spawn_fail_r;
  logic [4:0]  query_x_r, query_y_r, food_x_r, food_y_r;

  assign cand_x_s    = lfsr_r[4:0];
  assign cand_y_s    = lfsr_r[9:5];
  assign in_range_s  = ({1'b0, cand_x_s} < GRID_W_L) && ({1'b0, cand_y_s} < GRID_H_L);
  assign exhausted_s = (tries_r == MAX_TRIES_L);

`ifdef FOOD_LINEAR_PROBE_EN
  localparam logic [4:0] GRID_W_M1 = 5'(GRID_W - 1);
  localparam logic [4:0] GRID_H_M1 = 5'(GRID_H - 1);

  logic [4:0] scan_x_r, scan_y_r, scan_x_nxt_s, scan_y_nxt_s;
  logic       last_cell_s;

  assign last_cell_s = (scan_x_r == GRID_W_M1) && (scan_y_r == GRID_H_M1);

  // Raster-scan cursor: restart at (0,0) on entry, advance after each busy cell.
  always_comb begin
    scan_x_nxt_s = scan_x_r;
    scan_y_nxt_s = scan_y_r;
    if (state_nxt_s == ST_PROBE_Q) begin
      if (state_r == ST_PROBE_W) begin
        if (scan_x_r == GRID_W_M1) begin
          scan_x_nxt_s = 5'd0;
          scan_y_nxt_s = scan_y_r + 5'd1;
        end else begin
          scan_x_nxt_s = scan_x_r + 5'd1;
          scan_y_nxt_s = scan_y_r;
        end
      end else begin
        scan_x_nxt_s = 5'd0;
        scan_y_nxt_s = 5'd0;
      end
    end else begin
      scan_x_nxt_s = scan_x_r;
      scan_y_nxt_s = scan_y_r;
    end
  end

  // Raster-scan cursor register.
  always_ff @(posedge OSC or negedge rst) begin
    if (!rst) begin
      scan_x_r <= 5'd0;
      scan_y_r <= 5'd0;
    end else begin
      scan_x_r <= scan_x_nxt_s;
      scan_y_r <= scan_y_nxt_s;
    end
  end
`endif

  // Next-state logic for the draw / query / publish sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.spawn_req) state_nxt_s = ST_STEP;
        else               state_nxt_s = ST_IDLE;
      end
      ST_STEP:  state_nxt_s = ST_CHECK;
      ST_CHECK: begin
        if (in_range_s)       state_nxt_s = ST_QUERY;
        else if (exhausted_s) state_nxt_s = ST_EXHAUST;
        else                  state_nxt_s = ST_STEP;
      end
      ST_QUERY: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (!bus.occupied)    state_nxt_s = ST_DONE;
        else if (exhausted_s) state_nxt_s = ST_EXHAUST;
        else                  state_nxt_s = ST_STEP;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      ST_FAIL:  state_nxt_s = ST_IDLE;
`ifdef FOOD_LINEAR_PROBE_EN
      ST_PROBE_Q: state_nxt_s = ST_PROBE_W;
      ST_PROBE_W: begin
        if (!bus.occupied)    state_nxt_s = ST_DONE;
        else if (last_cell_s) state_nxt_s = ST_FAIL;
        else                  state_nxt_s = ST_PROBE_Q;
      end
`endif
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge OSC or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // LFSR: a seed load beats a same-cycle step; zero would lock up, so it maps to the init value.
  always_ff @(posedge OSC or negedge rst) begin
    if (!rst) begin
      lfsr_r <= LFSR_INIT;
    end else if (bus.seed_load) begin
      lfsr_r <= (bus.randomseed == 12'd0) ? LFSR_INIT : bus.randomseed;
    end else if (state_r == ST_STEP) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Draw counter: cleared on request acceptance, bumped once per draw.
  always_ff @(posedge OSC or negedge rst) begin
    if (!rst) begin
      tries_r <= 8'd0;
    end else if ((state_r == ST_IDLE) && bus.spawn_req) begin
      tries_r <= 8'd0;
    end else if (state_r == ST_STEP) begin
      tries_r <= tries_r + 8'd1;
    end
  end

  // Registered outputs, computed from the state being entered so pulses line up with it.
  always_ff @(posedge OSC or negedge rst) begin
    if (!rst) begin
      query_valid_r <= 1'b0;
      query_x_r     <= 5'd0;
      query_y_r     <= 5'd0;
      food_valid_r  <= 1'b0;
      food_x_r      <= 5'd0;
      food_y_r      <= 5'd0;
      busy_r        <= 1'b0;
      spawn_fail_r  <= 1'b0;
    end else begin
      busy_r        <= (state_nxt_s != ST_IDLE);
      spawn_fail_r  <= (state_nxt_s == ST_FAIL);
      food_valid_r  <= (state_nxt_s == ST_DONE);
`ifdef FOOD_LINEAR_PROBE_EN
      query_valid_r <= (state_nxt_s == ST_QUERY) || (state_nxt_s == ST_PROBE_Q);
      if (state_nxt_s == ST_PROBE_Q) begin
        query_x_r <= scan_x_nxt_s;
        query_y_r <= scan_y_nxt_s;
      end else if (state_nxt_s == ST_QUERY) begin
        query_x_r <= cand_x_s;
        query_y_r <= cand_y_s;
      end
`else
      query_valid_r <= (state_nxt_s == ST_QUERY);
      if (state_nxt_s == ST_QUERY) begin
        query_x_r <= cand_x_s;
        query_y_r <= cand_y_s;
      end
`endif
      if (state_nxt_s == ST_DONE) begin
        food_x_r <= query_x_r;
        food_y_r <= query_y_r;
      end
    end
  end

  assign bus.query_valid = query_valid_r;
  assign bus.query_x     = query_x_r;
  assign bus.query_y     = query_y_r;
  assign bus.food_valid  = food_valid_r;
  assign bus.food_x      = food_x_r;
  assign bus.food_y      = food_y_r;
  assign bus.busy        = busy_r;
  assign bus.spawn_fail  = spawn_fail_r;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner (MAX_TRIES=4). Expected cells come from
// hand-stepping the LFSR from 12'hDCF: DCF->B9F (31,28 reject) ->73F
// (31,25 reject) ->E7F (31,19) ->CFE (30,7); seed 12'h001 -> 002 (2,0).
module tb_food_spawner;

  logic osc = 1'b0;
  logic rst = 1'b0;
  always #5 osc = ~osc;

  food_spawner_if bus ();

  food_spawner #(.GRID_W(32), .GRID_H(24), .MAX_TRIES(4)) dut (
    .OSC (osc),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int occ_mode = 0;
  int n_query  = 0;
  int fv_cyc, sf_cyc, n_fv, n_sf, busy_at_fv, busy_after_fv;
  int reached_wait;
  logic [4:0] qx_q[$];
  logic [4:0] qy_q[$];

  // Body-storage responder: 0 free, 1 first query busy, 2 all busy, 3 only (2,0) free.
  always_comb begin
    bus.occupied = 1'b0;
    case (occ_mode)
      1:       bus.occupied = (n_query <= 1);
      2:       bus.occupied = 1'b1;
      3:       bus.occupied = !((bus.query_x == 5'd2) && (bus.query_y == 5'd0));
      default: bus.occupied = 1'b0;
    endcase
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qx_at(input int i);
    return (i < qx_q.size()) ? int'(qx_q[i]) : -1;
  endfunction

  function automatic int qy_at(input int i);
    return (i < qy_q.size()) ? int'(qy_q[i]) : -1;
  endfunction

  task automatic seed(input logic [11:0] s);
    bus.randomseed = s;
    bus.seed_load  = 1'b1;
    @(posedge osc); #1;
    bus.seed_load  = 1'b0;
  endtask

  // Issue a request and watch a bounded window; cycle 1 is the edge that accepts it.
  task automatic run_spawn(input bit hold, input int budget);
    fv_cyc = -1; sf_cyc = -1; n_fv = 0; n_sf = 0;
    busy_at_fv = -1; busy_after_fv = -1;
    qx_q.delete(); qy_q.delete(); n_query = 0;
    bus.spawn_req = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge osc); #1;
      if (!hold) bus.spawn_req = 1'b0;
      if ((fv_cyc > 0) && (c == fv_cyc + 1)) busy_after_fv = int'(bus.busy);
      if (bus.query_valid) begin
        qx_q.push_back(bus.query_x);
        qy_q.push_back(bus.query_y);
        n_query++;
      end
      if (bus.food_valid) begin
        n_fv++;
        if (fv_cyc < 0) begin
          fv_cyc     = c;
          busy_at_fv = int'(bus.busy);
        end
        bus.spawn_req = 1'b0;
      end
      if (bus.spawn_fail) begin
        n_sf++;
        if (sf_cyc < 0) sf_cyc = c;
        bus.spawn_req = 1'b0;
      end
    end
    bus.spawn_req = 1'b0;
  endtask

  initial begin
    bus.randomseed = 12'd0;
    bus.seed_load  = 1'b0;
    bus.spawn_req  = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge osc);
    #1;
    check_eq("rst_busy",       int'(bus.busy),        0);
    check_eq("rst_food_valid", int'(bus.food_valid),  0);
    check_eq("rst_query_valid",int'(bus.query_valid), 0);
    check_eq("rst_spawn_fail", int'(bus.spawn_fail),  0);
    check_eq("rst_food_x",     int'(bus.food_x),      0);
    check_eq("rst_query_y",    int'(bus.query_y),     0);
    rst = 1'b1;
    @(posedge osc); #1;

    // Test 1: two rejects then (31,19), free.
    occ_mode = 0;
    run_spawn(1'b0, 30);
    check_eq("t1_fv_cycle",   fv_cyc,             9);
    check_eq("t1_fv_count",   n_fv,               1);
    check_eq("t1_food_x",     int'(bus.food_x),   31);
    check_eq("t1_food_y",     int'(bus.food_y),   19);
    check_eq("t1_busy_at_fv", busy_at_fv,         1);
    check_eq("t1_busy_after", busy_after_fv,      0);
    check_eq("t1_queries",    n_query,            1);

    // Seed 1 gives an immediate in-range draw: 5-cycle latency.
    seed(12'h001);
    run_spawn(1'b0, 30);
    check_eq("lat_fv_cycle", fv_cyc,           5);
    check_eq("lat_food_x",   int'(bus.food_x), 2);
    check_eq("lat_food_y",   int'(bus.food_y), 0);

    // Test 2: zero seed behaves like the reset value.
    seed(12'h000);
    run_spawn(1'b0, 30);
    check_eq("t2_fv_cycle", fv_cyc,           9);
    check_eq("t2_food_x",   int'(bus.food_x), 31);
    check_eq("t2_food_y",   int'(bus.food_y), 19);

    // Test 3: first query busy, second (30,7) free.
    seed(12'h000);
    occ_mode = 1;
    run_spawn(1'b0, 30);
    check_eq("t3_fv_cycle", fv_cyc,           13);
    check_eq("t3_queries",  n_query,          2);
    check_eq("t3_q1_x",     qx_at(1),         30);
    check_eq("t3_q1_y",     qy_at(1),         7);
    check_eq("t3_food_x",   int'(bus.food_x), 30);
    check_eq("t3_food_y",   int'(bus.food_y), 7);

`ifndef FOOD_LINEAR_PROBE_EN
    // Test 4: all busy, budget of 4 draws exhausted -> one fail pulse.
    seed(12'h000);
    occ_mode = 2;
    run_spawn(1'b0, 30);
    check_eq("t4_sf_count", n_sf,             1);
    check_eq("t4_sf_cycle", sf_cyc,           13);
    check_eq("t4_fv_count", n_fv,             0);
    check_eq("t4_food_x",   int'(bus.food_x), 30);
    check_eq("t4_food_y",   int'(bus.food_y), 7);
`else
    // Test 5: exhaustion falls into the raster scan; (2,0) is the first free cell.
    seed(12'h000);
    occ_mode = 3;
    run_spawn(1'b0, 40);
    check_eq("t5_fv_cycle", fv_cyc,           19);
    check_eq("t5_sf_count", n_sf,             0);
    check_eq("t5_queries",  n_query,          5);
    check_eq("t5_q2_x",     qx_at(2),         0);
    check_eq("t5_q2_y",     qy_at(2),         0);
    check_eq("t5_q3_x",     qx_at(3),         1);
    check_eq("t5_q4_x",     qx_at(4),         2);
    check_eq("t5_q4_y",     qy_at(4),         0);
    check_eq("t5_food_x",   int'(bus.food_x), 2);
    check_eq("t5_food_y",   int'(bus.food_y), 0);
`endif

    // Test 6a: spawn_req held high while busy -> a single spawn.
    seed(12'h000);
    occ_mode = 0;
    run_spawn(1'b1, 30);
    check_eq("t6_fv_count", n_fv,             1);
    check_eq("t6_fv_cycle", fv_cyc,           9);
    check_eq("t6_food_x",   int'(bus.food_x), 31);

    // Test 6b: reset asserted while waiting for the occupied answer.
    seed(12'h000);
    reached_wait = 0;
    bus.spawn_req = 1'b1;
    @(posedge osc); #1;
    bus.spawn_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (reached_wait == 0) begin
        @(posedge osc); #1;
        if (bus.query_valid) reached_wait = 1;
      end
    end
    check_eq("t6_reach_query", reached_wait, 1);
    @(posedge osc); #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_busy",        int'(bus.busy),        0);
    check_eq("t6_rst_query_valid", int'(bus.query_valid), 0);
    check_eq("t6_rst_query_x",     int'(bus.query_x),     0);
    check_eq("t6_rst_food_x",      int'(bus.food_x),      0);
    check_eq("t6_rst_food_y",      int'(bus.food_y),      0);
    check_eq("t6_rst_food_valid",  int'(bus.food_valid),  0);
    check_eq("t6_rst_spawn_fail",  int'(bus.spawn_fail),  0);
    @(posedge osc); #1;
    rst = 1'b1;
    @(posedge osc); #1;
    // LFSR must be back at 12'hDCF: the first free cell is (31,19) again.
    run_spawn(1'b0, 30);
    check_eq("t6_post_fv_cycle", fv_cyc,           9);
    check_eq("t6_post_food_x",   int'(bus.food_x), 31);
    check_eq("t6_post_food_y",   int'(bus.food_y), 19);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
